// File: rtl/pla_eval_pkg.sv
// Shared types, default widths and the saturating counter helper for the PLA evaluation sequencer.
package pla_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam int unsigned DEF_IN_W   = 15;
    localparam int unsigned DEF_OUT_W  = 9;
    localparam int unsigned DEF_SETTLE = 2;
    localparam int unsigned DEF_CNT_W  = 24;
    localparam int unsigned SETTLE_W   = 8;

    // Adds b to a and clamps at the all-ones value of a w-bit counter; hit flags reaching that value.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w, output logic hit);
        logic [64:0] sum;
        logic [63:0] max;
        max     = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum     = {1'b0, a} + {1'b0, b};
        hit     = (sum >= {1'b0, max});
        sat_add = hit ? max : sum[63:0];
    endfunction

endpackage

// File: rtl/pla_eval_sequencer_popcount.sv
// Combinational population count of a W-bit vector.
module pla_popcount #(
    parameter  int unsigned W  = 9,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/pla_eval_sequencer.sv
// Drives vectors into a combinational PLA core, captures its response after a settle time and
// accumulates switching-activity counters. Optional per-output-bit counters: PLA_EVAL_PER_BIT_EN.
module pla_eval_sequencer
    import pla_eval_pkg::*;
#(
    parameter  int unsigned IN_W          = DEF_IN_W,
    parameter  int unsigned OUT_W         = DEF_OUT_W,
    parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE,
    parameter  int unsigned CNT_W         = DEF_CNT_W,
    localparam int unsigned SEL_W         = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    output logic [IN_W-1:0]  core_in,
    input  logic [OUT_W-1:0] core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_vec,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] in_tgl_cnt,
    output logic [CNT_W-1:0] out_tgl_cnt,
`ifdef PLA_EVAL_PER_BIT_EN
    input  logic [SEL_W-1:0] tgl_sel,
    output logic [CNT_W-1:0] bit_tgl_cnt,
`endif
    output logic             stat_sat
);

    localparam int unsigned IPC_W = $clog2(IN_W + 1);
    localparam int unsigned OPC_W = $clog2(OUT_W + 1);

    state_e               state_q;
    logic [SETTLE_W-1:0]  settle_cnt_q;
    logic [IN_W-1:0]      core_in_q;
    logic [OUT_W-1:0]     out_vec_q;
    logic                 out_valid_q;
    logic                 in_ready_q;

    logic [IN_W-1:0]      prev_in_q,  prev_in_d;
    logic [OUT_W-1:0]     prev_out_q, prev_out_d;
    logic                 first_q,    first_d;
    logic [CNT_W-1:0]     vec_cnt_q,  vec_cnt_d;
    logic [CNT_W-1:0]     in_tgl_q,   in_tgl_d;
    logic [CNT_W-1:0]     out_tgl_q,  out_tgl_d;
    logic                 sat_q,      sat_d;

    logic                 capture_c;
    logic [IN_W-1:0]      in_x_c;
    logic [OUT_W-1:0]     out_x_c;
    logic [IPC_W-1:0]     in_pc_c;
    logic [OPC_W-1:0]     out_pc_c;
    logic                 hit_v_c, hit_i_c, hit_o_c;

    assign capture_c = (state_q == ST_SETTLE) && (settle_cnt_q == '0);
    assign in_x_c    = core_in_q ^ prev_in_q;
    assign out_x_c   = core_out ^ prev_out_q;

    pla_popcount #(.W(IN_W))  u_in_pc  (.vec_i(in_x_c),  .cnt_o(in_pc_c));
    pla_popcount #(.W(OUT_W)) u_out_pc (.vec_i(out_x_c), .cnt_o(out_pc_c));

    // Handshake FSM; core_in is only ever reloaded on acceptance so it never glitches back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            core_in_q    <= '0;
            out_vec_q    <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        core_in_q    <= in_vec;
                        settle_cnt_q <= SETTLE_W'(SETTLE_CYCLES - 1);
                        in_ready_q   <= 1'b0;
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        out_vec_q   <= core_out;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PLA_EVAL_PER_BIT_EN
    logic [CNT_W-1:0] bit_cnt_q [OUT_W];
    logic [CNT_W-1:0] bit_cnt_d [OUT_W];
    logic [OUT_W-1:0] hit_b_c;
    logic [CNT_W-1:0] bit_rd_c;
    logic [CNT_W-1:0] bit_tgl_q;
`endif

    // Statistics next-state; a coincident clear overrides the capture entirely.
    always_comb begin
        vec_cnt_d  = vec_cnt_q;
        in_tgl_d   = in_tgl_q;
        out_tgl_d  = out_tgl_q;
        sat_d      = sat_q;
        first_d    = first_q;
        prev_in_d  = prev_in_q;
        prev_out_d = prev_out_q;
        hit_v_c    = 1'b0;
        hit_i_c    = 1'b0;
        hit_o_c    = 1'b0;
`ifdef PLA_EVAL_PER_BIT_EN
        hit_b_c    = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            bit_cnt_d[i] = bit_cnt_q[i];
        end
`endif
        if (capture_c) begin
            vec_cnt_d = CNT_W'(sat_add(64'(vec_cnt_q), 64'd1, CNT_W, hit_v_c));
            if (!first_q) begin
                in_tgl_d  = CNT_W'(sat_add(64'(in_tgl_q),  64'(in_pc_c),  CNT_W, hit_i_c));
                out_tgl_d = CNT_W'(sat_add(64'(out_tgl_q), 64'(out_pc_c), CNT_W, hit_o_c));
`ifdef PLA_EVAL_PER_BIT_EN
                for (int i = 0; i < int'(OUT_W); i++) begin
                    bit_cnt_d[i] = CNT_W'(sat_add(64'(bit_cnt_q[i]), 64'(out_x_c[i]),
                                                  CNT_W, hit_b_c[i]));
                end
`endif
            end
            sat_d      = sat_q | hit_v_c | hit_i_c | hit_o_c;
`ifdef PLA_EVAL_PER_BIT_EN
            sat_d      = sat_d | (|hit_b_c);
`endif
            prev_in_d  = core_in_q;
            prev_out_d = core_out;
            first_d    = 1'b0;
        end
        if (clr_stats) begin
            vec_cnt_d = '0;
            in_tgl_d  = '0;
            out_tgl_d = '0;
            sat_d     = 1'b0;
            first_d   = 1'b1;
`ifdef PLA_EVAL_PER_BIT_EN
            for (int i = 0; i < int'(OUT_W); i++) begin
                bit_cnt_d[i] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_q  <= '0;
            in_tgl_q   <= '0;
            out_tgl_q  <= '0;
            sat_q      <= 1'b0;
            first_q    <= 1'b1;
            prev_in_q  <= '0;
            prev_out_q <= '0;
        end else begin
            vec_cnt_q  <= vec_cnt_d;
            in_tgl_q   <= in_tgl_d;
            out_tgl_q  <= out_tgl_d;
            sat_q      <= sat_d;
            first_q    <= first_d;
            prev_in_q  <= prev_in_d;
            prev_out_q <= prev_out_d;
        end
    end

`ifdef PLA_EVAL_PER_BIT_EN
    // Per-bit read mux; selections beyond OUT_W-1 return 0.
    always_comb begin
        bit_rd_c = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (SEL_W'(i) == tgl_sel) begin
                bit_rd_c = bit_cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OUT_W); i++) begin
                bit_cnt_q[i] <= '0;
            end
            bit_tgl_q <= '0;
        end else begin
            for (int i = 0; i < int'(OUT_W); i++) begin
                bit_cnt_q[i] <= bit_cnt_d[i];
            end
            bit_tgl_q <= bit_rd_c;
        end
    end

    assign bit_tgl_cnt = bit_tgl_q;
`endif

    assign in_ready    = in_ready_q;
    assign core_in     = core_in_q;
    assign out_valid   = out_valid_q;
    assign out_vec     = out_vec_q;
    assign vec_cnt     = vec_cnt_q;
    assign in_tgl_cnt  = in_tgl_q;
    assign out_tgl_cnt = out_tgl_q;
    assign stat_sat    = sat_q;

endmodule

// File: tb/tb_pla_eval_sequencer.sv
// Directed bench: loopback core (core_out = core_in[8:0]) on a 24-bit-counter DUT and a 4-bit-counter DUT.
module tb_pla_eval_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_s_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, clr_stats = 1'b0, stat_sat;
    logic [14:0] in_vec = '0, core_in;
    logic [8:0]  core_out, out_vec;
    logic [23:0] vec_cnt, in_tgl_cnt, out_tgl_cnt;

    logic        in_valid_s = 1'b0, in_ready_s, out_valid_s, out_ready_s = 1'b0, clr_stats_s = 1'b0;
    logic        stat_sat_s;
    logic [14:0] in_vec_s = '0, core_in_s;
    logic [8:0]  core_out_s, out_vec_s;
    logic [3:0]  vec_cnt_s, in_tgl_cnt_s, out_tgl_cnt_s;

`ifdef PLA_EVAL_PER_BIT_EN
    logic [3:0]  tgl_sel = '0, tgl_sel_s = '0;
    logic [23:0] bit_tgl_cnt;
    logic [3:0]  bit_tgl_cnt_s;
`endif

    int checks = 0;
    int errors = 0;

    assign core_out   = core_in[8:0];
    assign core_out_s = core_in_s[8:0];

    always #5 clk = ~clk;

    pla_eval_sequencer #(.IN_W(15), .OUT_W(9), .SETTLE_CYCLES(2), .CNT_W(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .core_in(core_in), .core_out(core_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .clr_stats(clr_stats), .vec_cnt(vec_cnt), .in_tgl_cnt(in_tgl_cnt),
        .out_tgl_cnt(out_tgl_cnt),
`ifdef PLA_EVAL_PER_BIT_EN
        .tgl_sel(tgl_sel), .bit_tgl_cnt(bit_tgl_cnt),
`endif
        .stat_sat(stat_sat));

    pla_eval_sequencer #(.IN_W(15), .OUT_W(9), .SETTLE_CYCLES(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_s_n), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_vec(in_vec_s),
        .core_in(core_in_s), .core_out(core_out_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_vec(out_vec_s), .clr_stats(clr_stats_s), .vec_cnt(vec_cnt_s), .in_tgl_cnt(in_tgl_cnt_s),
        .out_tgl_cnt(out_tgl_cnt_s),
`ifdef PLA_EVAL_PER_BIT_EN
        .tgl_sel(tgl_sel_s), .bit_tgl_cnt(bit_tgl_cnt_s),
`endif
        .stat_sat(stat_sat_s));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input bit s, input logic [14:0] v);
        int n = 0;
        while (!(s ? in_ready_s : in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(s ? "sat_in_ready_wait" : "in_ready_wait", 64'(s ? in_ready_s : in_ready), 64'd1);
        if (s) begin in_valid_s = 1'b1; in_vec_s = v; end
        else   begin in_valid   = 1'b1; in_vec   = v; end
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_s = 1'b0;
    endtask

    task automatic wait_out(input bit s);
        int n = 0;
        while (!(s ? out_valid_s : out_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(s ? "sat_out_valid_wait" : "out_valid_wait", 64'(s ? out_valid_s : out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_core_in", 64'(core_in), 64'h0);
        chk("rst_out_vec", 64'(out_vec), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_vec_cnt", 64'(vec_cnt), 64'h0);
        chk("rst_stat_sat", 64'(stat_sat), 64'h0);
        rst_n = 1'b1;
        rst_s_n = 1'b1;
        @(negedge clk);

        // Vector 1: exact latency, out_valid visible after the third edge counting the accept edge
        in_valid = 1'b1; in_vec = 15'h0155;
        @(negedge clk); in_valid = 1'b0;
        chk("lat_edge1", 64'(out_valid), 64'h0);
        @(negedge clk);
        chk("lat_edge2", 64'(out_valid), 64'h0);
        @(negedge clk);
        chk("lat_edge3", 64'(out_valid), 64'h1);
        chk("v1_out_vec", 64'(out_vec), 64'h155);
        chk("v1_core_in", 64'(core_in), 64'h0155);
        chk("v1_vec_cnt", 64'(vec_cnt), 64'd1);
        chk("v1_in_tgl", 64'(in_tgl_cnt), 64'd0);
        chk("v1_out_tgl", 64'(out_tgl_cnt), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("v1_drop_valid", 64'(out_valid), 64'h0);
        chk("v1_idle_ready", 64'(in_ready), 64'h1);

        // Vector 2: 0x0155 ^ 0x00AA = 0x01FF -> 9 toggles in and out
        send(1'b0, 15'h00AA);
        wait_out(1'b0);
        chk("v2_out_vec", 64'(out_vec), 64'h0AA);
        chk("v2_vec_cnt", 64'(vec_cnt), 64'd2);
        chk("v2_in_tgl", 64'(in_tgl_cnt), 64'd9);
        chk("v2_out_tgl", 64'(out_tgl_cnt), 64'd9);
        @(negedge clk);

        // Vector 3 held off: 0x00AA^0x1234 has 7 ones; 0x0AA^0x034 has 5 ones
        out_ready = 1'b0;
        send(1'b0, 15'h1234);
        wait_out(1'b0);
        chk("v3_out_vec", 64'(out_vec), 64'h034);
        in_valid = 1'b1; in_vec = 15'h7FFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_vec", 64'(out_vec), 64'h034);
            chk("hold_in_ready", 64'(in_ready), 64'h0);
            chk("hold_out_valid", 64'(out_valid), 64'h1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_out_valid", 64'(out_valid), 64'h0);
        chk("rel_in_ready", 64'(in_ready), 64'h1);
        chk("rel_core_in", 64'(core_in), 64'h1234);
        chk("v3_vec_cnt", 64'(vec_cnt), 64'd3);
        chk("v3_in_tgl", 64'(in_tgl_cnt), 64'd16);
        chk("v3_out_tgl", 64'(out_tgl_cnt), 64'd14);

        // Vector 4: clr_stats on the capture edge wins over that capture
        in_valid = 1'b1; in_vec = 15'h0F0F;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); clr_stats = 1'b1;
        @(negedge clk); clr_stats = 1'b0;
        chk("clr_out_valid", 64'(out_valid), 64'h1);
        chk("clr_out_vec", 64'(out_vec), 64'h10F);
        chk("clr_vec_cnt", 64'(vec_cnt), 64'd0);
        chk("clr_in_tgl", 64'(in_tgl_cnt), 64'd0);
        chk("clr_out_tgl", 64'(out_tgl_cnt), 64'd0);
        chk("clr_stat_sat", 64'(stat_sat), 64'h0);
        @(negedge clk);

        // Vector 5 differs by 3 bits but is first after clear
        send(1'b0, 15'h0F08);
        wait_out(1'b0);
        chk("v5_out_vec", 64'(out_vec), 64'h108);
        chk("v5_vec_cnt", 64'(vec_cnt), 64'd1);
        chk("v5_in_tgl", 64'(in_tgl_cnt), 64'd0);
        chk("v5_out_tgl", 64'(out_tgl_cnt), 64'd0);
        @(negedge clk);

        send(1'b0, 15'h0F0B);
        wait_out(1'b0);
        chk("v6_vec_cnt", 64'(vec_cnt), 64'd2);
        chk("v6_in_tgl", 64'(in_tgl_cnt), 64'd2);
        chk("v6_out_tgl", 64'(out_tgl_cnt), 64'd2);
        @(negedge clk);

        // Saturation on the 4-bit-counter instance
        out_ready_s = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, (i % 2 == 1) ? 15'h01FF : 15'h0000);
            wait_out(1'b1);
            if (i == 1) begin
                chk("sat_pre_out_tgl", 64'(out_tgl_cnt_s), 64'd9);
                chk("sat_pre_flag", 64'(stat_sat_s), 64'h0);
            end
            @(negedge clk);
        end
        chk("sat_out_tgl", 64'(out_tgl_cnt_s), 64'd15);
        chk("sat_in_tgl", 64'(in_tgl_cnt_s), 64'd15);
        chk("sat_vec_cnt", 64'(vec_cnt_s), 64'd15);
        chk("sat_flag", 64'(stat_sat_s), 64'h1);
        clr_stats_s = 1'b1;
        @(negedge clk); clr_stats_s = 1'b0;
        chk("sat_clr_flag", 64'(stat_sat_s), 64'h0);
        chk("sat_clr_out_tgl", 64'(out_tgl_cnt_s), 64'd0);
        chk("sat_clr_vec_cnt", 64'(vec_cnt_s), 64'd0);

        // Reset asserted mid-SETTLE discards the pending result
        in_valid = 1'b1; in_vec = 15'h5555;
        @(negedge clk); in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_core_in", 64'(core_in), 64'h0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'h1);
        chk("mid_rst_vec_cnt", 64'(vec_cnt), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_valid", 64'(out_valid), 64'h0);
        send(1'b0, 15'h0003);
        wait_out(1'b0);
        chk("post_rst_out_vec", 64'(out_vec), 64'h003);
        chk("post_rst_vec_cnt", 64'(vec_cnt), 64'd1);
        chk("post_rst_in_tgl", 64'(in_tgl_cnt), 64'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
